rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameter NUM_REGS, 32, number of architectural registers; x0 hardwired to zero.
REQ-002 Parameter XLEN, 32, data width.
REQ-003 Parameter TAG_W, 3, ROB tag width (8-entry ROB).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 regfile_allocate  in  1  ROB dispatch: mark alloc_rd in flight.
REQ-007 alloc_rd  in  5  destination register being allocated.
REQ-008 alloc_tag  in  TAG_W  ROB entry producing alloc_rd.
REQ-009 regfile_load  in  1  ROB in-order commit strobe.
REQ-010 commit_rd  in  5  register being committed.
REQ-011 commit_tag  in  TAG_W  ROB entry being committed.
REQ-012 commit_data  in  XLEN  commit value for non-load instructions.
REQ-013 ld_commit_sel  in  1  1: commit value is dmem_rdata; 0: commit_data.
REQ-014 dmem_rdata  in  XLEN  d-cache load data.
REQ-015 cdb  in  tomasula_types::cdb_data  broadcast {valid, tag, data}.
REQ-016 flush  in  1  branch mispredict: discard all in-flight renames.
REQ-017 rs1_idx, rs2_idx  in  5 each  operand read addresses.
REQ-018 rs1_data, rs2_data  out  XLEN each  operand value.
REQ-019 rs1_tag, rs2_tag  out  TAG_W each  producing ROB tag when not ready.
REQ-020 rs1_ready, rs2_ready  out  1 each  1: data valid; 0: wait on tag.
REQ-021 st_commit  in  5  store-source register from ROB.
REQ-022 st_data  out  XLEN  registered value of st_commit.
REQ-023 inflight_cnt  out  6  number of busy registers.

Function
REQ-024 Per register: data[XLEN], busy, tag[TAG_W]; reads are combinational from current state.
REQ-025 Read: busy=0 -> data, ready=1, tag=0; busy=1 -> ready=0, tag=stored tag, data=stored data.
REQ-026 Index 0 SHALL read data=0, ready=1, tag=0; allocate/commit to x0 ignored.
REQ-027 Allocate (x0 excluded): next cycle busy=1, tag=alloc_tag; data unchanged.
REQ-028 Commit: data[commit_rd] <= (ld_commit_sel ? dmem_rdata : commit_data); busy cleared only if busy=1 and stored tag==commit_tag.
REQ-029 Commit with tag mismatch (newer rename in flight): data written, busy and tag retained.
REQ-030 Allocate and commit same rd same cycle: data written; busy=1, tag=alloc_tag (allocate wins).
REQ-031 Reads in the commit cycle return pre-commit state; no commit-to-read bypass.
REQ-032 flush: next cycle all busy=0, tags=0; allocate in same cycle ignored; commit in same cycle still writes data.
REQ-033 st_data <= data[st_commit] every cycle (1-cycle latency, pre-commit value); st_commit=0 gives 0.
REQ-034 inflight_cnt = popcount(busy), range 0..31, reflects current state.

Reset
REQ-035 rst: all data=0, busy=0, tags=0, st_data=0, inflight_cnt=0; overrides allocate, commit and flush in the same cycle.
REQ-036 rst mid-operation discards all renames; first post-reset read of any register returns 0, ready=1.

Configuration
REQ-037 Macro RENAME_REGFILE_CDB_BYPASS_EN defined: busy register whose tag matches cdb.tag with cdb.valid=1 reads data=cdb.data, ready=1 combinationally; state unchanged.
REQ-038 Macro undefined: cdb input unused; reads follow REQ-025 only.

Structure
REQ-039 cdb_data struct and TAG_W constant belong in tomasula_types; op_t remains in rv32i_types.
REQ-040 One sub-module rf_read_port (index decode, x0 rule, optional CDB bypass), instantiated twice.

Verification
REQ-041 Reset, read x5 -> data=0, ready=1, tag=0, inflight_cnt=0.
REQ-042 Allocate x5 tag 3; next cycle read x5 -> ready=0, tag=3, inflight_cnt=1; commit x5 tag 3 data 0xDEADBEEF -> next cycle ready=1, data=0xDEADBEEF, inflight_cnt=0.
REQ-043 Allocate x7 tag 1, allocate x7 tag 4, commit x7 tag 1 data 0x11 -> x7 data=0x11, ready=0, tag=4.
REQ-044 Allocate x2,x3,x4 tags 0,1,2; flush with simultaneous allocate x9 tag 3 and commit x2 tag 0 ld_commit_sel=1 dmem_rdata=0xCAFE -> all ready=1, x2=0xCAFE, inflight_cnt=0.
REQ-045 Bypass build: x6 busy tag 2, cdb {1,2,0x55} -> rs1_data=0x55, rs1_ready=1 same cycle; non-bypass build -> rs1_ready=0, tag=2.
REQ-046 Allocate x0 tag 5, commit x0 data 0xFF, st_commit=0 -> rs1 x0 data=0, ready=1; st_data=0 next cycle.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// Shared types for the rename register file.
// cdb_data/TAG_W live in tomasula_types; op_t in rv32i_types.
package tomasula_types;
  localparam int TAG_W = 3;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } cdb_data;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction
endpackage

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } op_t;
endpackage

// File: rtl/rename_regfile_if.sv
// ROB / dispatch / operand-read bundle for rename_regfile.
// master = ROB+dispatch side, slave = register file.
interface rename_regfile_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
);
  import tomasula_types::*;

  logic             regfile_allocate;
  logic [4:0]       alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic             regfile_load;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_data;
  logic             ld_commit_sel;
  logic [XLEN-1:0]  dmem_rdata;
  cdb_data          cdb;
  logic             flush;
  logic [4:0]       rs1_idx;
  logic [4:0]       rs2_idx;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic             rs1_ready;
  logic             rs2_ready;
  logic [4:0]       st_commit;
  logic [XLEN-1:0]  st_data;
  logic [5:0]       inflight_cnt;

  modport master (
    output regfile_allocate, alloc_rd, alloc_tag,
    output regfile_load, commit_rd, commit_tag,
    output commit_data, ld_commit_sel, dmem_rdata,
    output cdb, flush, rs1_idx, rs2_idx, st_commit,
    input  rs1_data, rs2_data, rs1_tag, rs2_tag,
    input  rs1_ready, rs2_ready, st_data, inflight_cnt
  );

  modport slave (
    input  regfile_allocate, alloc_rd, alloc_tag,
    input  regfile_load, commit_rd, commit_tag,
    input  commit_data, ld_commit_sel, dmem_rdata,
    input  cdb, flush, rs1_idx, rs2_idx, st_commit,
    output rs1_data, rs2_data, rs1_tag, rs2_tag,
    output rs1_ready, rs2_ready, st_data, inflight_cnt
  );
endinterface

// File: rtl/rename_regfile_rf_read_port.sv
// One combinational operand read port with x0 rule.
// Define RENAME_REGFILE_CDB_BYPASS_EN to forward matching CDB data.
module rf_read_port
  import tomasula_types::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 3
) (
  input  logic [4:0]                     idx,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  regs_data,
  input  logic [NUM_REGS-1:0]            regs_busy,
  input  logic [NUM_REGS-1:0][TAG_W-1:0] regs_tag,
  input  cdb_data                        cdb,
  output logic [XLEN-1:0]                data,
  output logic [TAG_W-1:0]               tag,
  output logic                           ready
);
`ifndef RENAME_REGFILE_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^cdb;
`endif

  always_comb begin
    data  = regs_data[idx];
    ready = 1'b1;
    tag   = '0;
    if (regs_busy[idx]) begin
      ready = 1'b0;
      tag   = regs_tag[idx];
`ifdef RENAME_REGFILE_CDB_BYPASS_EN
      if (cdb.valid && cdb.tag == regs_tag[idx]) begin
        data  = cdb.data;
        ready = 1'b1;
        tag   = '0;
      end
`endif
    end
    if (idx == 5'd0) begin
      data  = '0;
      ready = 1'b1;
      tag   = '0;
    end
  end
endmodule

// File: rtl/rename_regfile.sv
// Architectural regfile with per-register rename busy/tag state.
// Optional CDB read bypass: RENAME_REGFILE_CDB_BYPASS_EN.
module rename_regfile
  import tomasula_types::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 3
) (
  input logic       clk,
  input logic       rst,
  rename_regfile_if.slave rf
);
  logic [NUM_REGS-1:0][XLEN-1:0]  data_q;
  logic [NUM_REGS-1:0]            busy_q;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q;
  logic [XLEN-1:0]                st_q;
  logic [XLEN-1:0]                wdata;
  logic                           do_alloc;
  logic                           do_commit;
  logic                           tag_hit;

  assign wdata = rf.ld_commit_sel ? rf.dmem_rdata
                                  : rf.commit_data;
  assign do_alloc  = rf.regfile_allocate
                   && rf.alloc_rd != 5'd0;
  assign do_commit = rf.regfile_load
                   && rf.commit_rd != 5'd0;
  assign tag_hit   = busy_q[rf.commit_rd]
                   && tag_q[rf.commit_rd] == rf.commit_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
      st_q   <= '0;
    end else begin
      st_q <= (rf.st_commit == 5'd0) ? '0
                                     : data_q[rf.st_commit];
      if (do_commit)
        data_q[rf.commit_rd] <= wdata;
      if (rf.flush) begin
        busy_q <= '0;
        tag_q  <= '0;
      end else begin
        if (do_commit && tag_hit)
          busy_q[rf.commit_rd] <= 1'b0;
        // allocate after commit so a same-rd rename wins
        if (do_alloc) begin
          busy_q[rf.alloc_rd] <= 1'b1;
          tag_q[rf.alloc_rd]  <= rf.alloc_tag;
        end
      end
    end
  end

  assign rf.st_data      = st_q;
  assign rf.inflight_cnt = popcount32(busy_q);

  rf_read_port #(
    .NUM_REGS(NUM_REGS), .XLEN(XLEN), .TAG_W(TAG_W)
  ) u_rs1 (
    .idx       (rf.rs1_idx),
    .regs_data (data_q),
    .regs_busy (busy_q),
    .regs_tag  (tag_q),
    .cdb       (rf.cdb),
    .data      (rf.rs1_data),
    .tag       (rf.rs1_tag),
    .ready     (rf.rs1_ready)
  );

  rf_read_port #(
    .NUM_REGS(NUM_REGS), .XLEN(XLEN), .TAG_W(TAG_W)
  ) u_rs2 (
    .idx       (rf.rs2_idx),
    .regs_data (data_q),
    .regs_busy (busy_q),
    .regs_tag  (tag_q),
    .cdb       (rf.cdb),
    .data      (rf.rs2_data),
    .tag       (rf.rs2_tag),
    .ready     (rf.rs2_ready)
  );
endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile.
// Honours RENAME_REGFILE_CDB_BYPASS_EN for the CDB scenario.
module tb_rename_regfile;
  import tomasula_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rename_regfile_if #(.XLEN(32), .TAG_W(3)) rf ();

  rename_regfile dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.regfile_allocate = 1'b0;
    rf.alloc_rd         = '0;
    rf.alloc_tag        = '0;
    rf.regfile_load     = 1'b0;
    rf.commit_rd        = '0;
    rf.commit_tag       = '0;
    rf.commit_data      = '0;
    rf.ld_commit_sel    = 1'b0;
    rf.dmem_rdata       = '0;
    rf.cdb              = '0;
    rf.flush            = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd,
                       input logic [2:0] t);
    rf.regfile_allocate = 1'b1;
    rf.alloc_rd         = rd;
    rf.alloc_tag        = t;
  endtask

  task automatic commit(input logic [4:0]  rd,
                        input logic [2:0]  t,
                        input logic [31:0] d);
    rf.regfile_load = 1'b1;
    rf.commit_rd    = rd;
    rf.commit_tag   = t;
    rf.commit_data  = d;
  endtask

  task automatic test_reset();
    idle();
    rf.rs1_idx   = 5'd5;
    rf.rs2_idx   = 5'd0;
    rf.st_commit = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_ready !== 1'b1
        || rf.rs1_tag !== 3'd0) begin
      failures++;
      $display("FAIL reset_x5 got d=%h r=%b t=%0d want 0 1 0",
               rf.rs1_data, rf.rs1_ready, rf.rs1_tag);
    end
    checks++;
    if (rf.inflight_cnt !== 6'd0 || rf.st_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt got cnt=%0d st=%h want 0 0",
               rf.inflight_cnt, rf.st_data);
    end
  endtask

  task automatic test_alloc_commit();
    alloc(5'd5, 3'd3);
    tick();
    idle();
    rf.rs1_idx = 5'd5;
    #1;
    checks++;
    if (rf.rs1_ready !== 1'b0 || rf.rs1_tag !== 3'd3
        || rf.inflight_cnt !== 6'd1) begin
      failures++;
      $display("FAIL alloc_x5 got r=%b t=%0d cnt=%0d want 0 3 1",
               rf.rs1_ready, rf.rs1_tag, rf.inflight_cnt);
    end
    commit(5'd5, 3'd3, 32'hDEADBEEF);
    #1;
    checks++;
    if (rf.rs1_ready !== 1'b0 || rf.rs1_data !== 32'd0) begin
      failures++;
      $display("FAIL no_bypass got r=%b d=%h want 0 0",
               rf.rs1_ready, rf.rs1_data);
    end
    tick();
    idle();
    checks++;
    if (rf.rs1_ready !== 1'b1 || rf.rs1_data !== 32'hDEADBEEF
        || rf.inflight_cnt !== 6'd0) begin
      failures++;
      $display("FAIL commit_x5 got r=%b d=%h cnt=%0d want 1 deadbeef 0",
               rf.rs1_ready, rf.rs1_data, rf.inflight_cnt);
    end
  endtask

  task automatic test_tag_mismatch();
    alloc(5'd7, 3'd1);
    tick();
    alloc(5'd7, 3'd4);
    tick();
    idle();
    commit(5'd7, 3'd1, 32'h11);
    tick();
    idle();
    rf.rs2_idx = 5'd7;
    #1;
    checks++;
    if (rf.rs2_data !== 32'h11 || rf.rs2_ready !== 1'b0
        || rf.rs2_tag !== 3'd4) begin
      failures++;
      $display("FAIL tag_mismatch got d=%h r=%b t=%0d want 11 0 4",
               rf.rs2_data, rf.rs2_ready, rf.rs2_tag);
    end
    commit(5'd7, 3'd4, 32'h22);
    tick();
    idle();
    checks++;
    if (rf.rs2_data !== 32'h22 || rf.rs2_ready !== 1'b1) begin
      failures++;
      $display("FAIL tag_match got d=%h r=%b want 22 1",
               rf.rs2_data, rf.rs2_ready);
    end
  endtask

  task automatic test_same_cycle();
    alloc(5'd8, 3'd5);
    commit(5'd8, 3'd5, 32'h33);
    tick();
    idle();
    rf.rs1_idx = 5'd8;
    #1;
    checks++;
    if (rf.rs1_data !== 32'h33 || rf.rs1_ready !== 1'b0
        || rf.rs1_tag !== 3'd5 || rf.inflight_cnt !== 6'd1) begin
      failures++;
      $display("FAIL alloc_wins got d=%h r=%b t=%0d cnt=%0d want 33 0 5 1",
               rf.rs1_data, rf.rs1_ready, rf.rs1_tag,
               rf.inflight_cnt);
    end
  endtask

  task automatic test_flush();
    alloc(5'd2, 3'd0);
    tick();
    alloc(5'd3, 3'd1);
    tick();
    alloc(5'd4, 3'd2);
    tick();
    idle();
    checks++;
    if (rf.inflight_cnt !== 6'd4) begin
      failures++;
      $display("FAIL cnt_four got %0d want 4", rf.inflight_cnt);
    end
    rf.flush = 1'b1;
    alloc(5'd9, 3'd3);
    commit(5'd2, 3'd0, 32'h1234);
    rf.ld_commit_sel = 1'b1;
    rf.dmem_rdata    = 32'hCAFE;
    tick();
    idle();
    rf.rs1_idx = 5'd2;
    rf.rs2_idx = 5'd9;
    #1;
    checks++;
    if (rf.rs1_data !== 32'hCAFE || rf.rs1_ready !== 1'b1
        || rf.rs2_ready !== 1'b1 || rf.rs2_data !== 32'd0) begin
      failures++;
      $display("FAIL flush_x2x9 got d=%h r=%b r9=%b d9=%h want cafe 1 1 0",
               rf.rs1_data, rf.rs1_ready, rf.rs2_ready,
               rf.rs2_data);
    end
    rf.rs1_idx = 5'd3;
    rf.rs2_idx = 5'd4;
    #1;
    checks++;
    if (rf.rs1_ready !== 1'b1 || rf.rs2_ready !== 1'b1
        || rf.inflight_cnt !== 6'd0) begin
      failures++;
      $display("FAIL flush_all got r3=%b r4=%b cnt=%0d want 1 1 0",
               rf.rs1_ready, rf.rs2_ready, rf.inflight_cnt);
    end
  endtask

  task automatic test_cdb();
    logic exp_ready;
    logic [31:0] exp_data;
    logic [2:0]  exp_tag;
`ifdef RENAME_REGFILE_CDB_BYPASS_EN
    exp_ready = 1'b1;
    exp_data  = 32'h55;
    exp_tag   = 3'd0;
`else
    exp_ready = 1'b0;
    exp_data  = 32'd0;
    exp_tag   = 3'd2;
`endif
    alloc(5'd6, 3'd2);
    tick();
    idle();
    rf.rs1_idx   = 5'd6;
    rf.cdb.valid = 1'b1;
    rf.cdb.tag   = 3'd2;
    rf.cdb.data  = 32'h55;
    #1;
    checks++;
    if (rf.rs1_ready !== exp_ready || rf.rs1_data !== exp_data
        || rf.rs1_tag !== exp_tag) begin
      failures++;
      $display("FAIL cdb_hit got r=%b d=%h t=%0d want %b %h %0d",
               rf.rs1_ready, rf.rs1_data, rf.rs1_tag,
               exp_ready, exp_data, exp_tag);
    end
    rf.cdb.tag = 3'd3;
    #1;
    checks++;
    if (rf.rs1_ready !== 1'b0 || rf.rs1_tag !== 3'd2) begin
      failures++;
      $display("FAIL cdb_miss got r=%b t=%0d want 0 2",
               rf.rs1_ready, rf.rs1_tag);
    end
    rf.cdb = '0;
    tick();
    checks++;
    if (rf.rs1_ready !== 1'b0 || rf.inflight_cnt !== 6'd1) begin
      failures++;
      $display("FAIL cdb_state got r=%b cnt=%0d want 0 1",
               rf.rs1_ready, rf.inflight_cnt);
    end
    rf.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_x0();
    alloc(5'd0, 3'd5);
    commit(5'd0, 3'd5, 32'hFF);
    rf.st_commit = 5'd0;
    tick();
    idle();
    rf.rs1_idx = 5'd0;
    #1;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_ready !== 1'b1
        || rf.rs1_tag !== 3'd0 || rf.inflight_cnt !== 6'd0) begin
      failures++;
      $display("FAIL x0_read got d=%h r=%b t=%0d cnt=%0d want 0 1 0 0",
               rf.rs1_data, rf.rs1_ready, rf.rs1_tag,
               rf.inflight_cnt);
    end
    tick();
    checks++;
    if (rf.st_data !== 32'd0) begin
      failures++;
      $display("FAIL x0_st got %h want 0", rf.st_data);
    end
  endtask

  task automatic test_st_data();
    rf.st_commit = 5'd5;
    commit(5'd5, 3'd0, 32'h77);
    tick();
    idle();
    rf.rs1_idx = 5'd5;
    #1;
    checks++;
    if (rf.st_data !== 32'hDEADBEEF || rf.rs1_data !== 32'h77) begin
      failures++;
      $display("FAIL st_pre got st=%h d=%h want deadbeef 77",
               rf.st_data, rf.rs1_data);
    end
    tick();
    checks++;
    if (rf.st_data !== 32'h77) begin
      failures++;
      $display("FAIL st_post got %h want 77", rf.st_data);
    end
  endtask

  task automatic test_midreset();
    alloc(5'd10, 3'd1);
    tick();
    alloc(5'd11, 3'd2);
    commit(5'd5, 3'd0, 32'h99);
    rf.flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    rf.rs1_idx = 5'd5;
    rf.rs2_idx = 5'd10;
    #1;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_ready !== 1'b1
        || rf.rs2_ready !== 1'b1 || rf.inflight_cnt !== 6'd0
        || rf.st_data !== 32'd0) begin
      failures++;
      $display("FAIL midreset got d=%h r=%b r10=%b cnt=%0d st=%h want 0 1 1 0 0",
               rf.rs1_data, rf.rs1_ready, rf.rs2_ready,
               rf.inflight_cnt, rf.st_data);
    end
    rf.rs1_idx = 5'd11;
    #1;
    checks++;
    if (rf.rs1_ready !== 1'b1 || rf.rs1_tag !== 3'd0) begin
      failures++;
      $display("FAIL midreset_x11 got r=%b t=%0d want 1 0",
               rf.rs1_ready, rf.rs1_tag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_alloc_commit();
    test_tag_mismatch();
    test_same_cycle();
    test_flush();
    test_cdb();
    test_x0();
    test_st_data();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
